// File: rtl/qspi_flash_responder.sv
// ---------------------------------------------------------------------------
// qspi_flash_responder: oversampled SPI/QSPI flash read responder (0x03, 0xEB)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module qspi_flash_responder #(
  parameter int ADDR_WIDTH        = 24,
  parameter int QUAD_DUMMY_CYCLES = 4,
  parameter int MEM_LATENCY       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flash_clk,
  input  logic                  flash_csn,
  input  logic [3:0]            io_in,
  output logic [3:0]            io_out,
  output logic [3:0]            io_out_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [7:0]            mem_data,
  output logic                  continuous_mode
);

  typedef enum logic [3:0] {
    IDLE, CMD, ADDR_S, ADDR_Q, MODE, DUMMY, DATA_S, DATA_Q, IGNORE
  } state_t;

  localparam logic [4:0] DUMMY_LAST = 5'(QUAD_DUMMY_CYCLES - 1);

  state_t state, next_state;

  logic                   sclk, sclk_d, csn_s;
  logic [3:0]             io_s;
  logic                   rise, fall, phase_done;
  logic [4:0]             cnt;
  logic [2:0]             bcnt;
  logic [22:0]            sr;
  logic [7:0]             cur, nxt, src, cmd_byte;
  logic [23:0]            addr_full;
  logic [MEM_LATENCY-1:0] rd_pipe;
  logic                   data_valid, quad_data;

  assign rise       = sclk & ~sclk_d;
  assign fall       = ~sclk & sclk_d;
  assign cmd_byte   = {sr[6:0], io_s[0]};
  assign addr_full  = (state == ADDR_Q) ? {sr[19:0], io_s} : {sr[22:0], io_s[0]};
  assign data_valid = rd_pipe[MEM_LATENCY-1];
  // Bypass lets the first byte start on the same clk its read data lands.
  assign src        = data_valid ? mem_data : nxt;
  assign quad_data  = (state == DATA_Q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk   <= 1'b0;
      sclk_d <= 1'b0;
      csn_s  <= 1'b1;
      io_s   <= 4'h0;
    end else begin
      sclk   <= flash_clk;
      sclk_d <= sclk;
      csn_s  <= flash_csn;
      io_s   <= io_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    phase_done = 1'b0;
    case (state)
      IDLE:   if (rise) next_state = continuous_mode ? ADDR_Q : CMD;
      CMD:    if (rise && cnt == 5'd7) begin
                phase_done = 1'b1;
                case (cmd_byte)
                  8'h03:   next_state = ADDR_S;
                  8'hEB:   next_state = ADDR_Q;
                  default: next_state = IGNORE;
                endcase
              end
      ADDR_S: if (rise && cnt == 5'd23) begin
                phase_done = 1'b1;
                next_state = DATA_S;
              end
      ADDR_Q: if (rise && cnt == 5'd5) begin
                phase_done = 1'b1;
                next_state = MODE;
              end
      MODE:   if (rise && cnt == 5'd1) begin
                phase_done = 1'b1;
                next_state = (QUAD_DUMMY_CYCLES == 0) ? DATA_Q : DUMMY;
              end
      DUMMY:  if (rise && cnt == DUMMY_LAST) begin
                phase_done = 1'b1;
                next_state = DATA_Q;
              end
      default: ;
    endcase
    if (csn_s) next_state = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt             <= 5'd0;
      bcnt            <= 3'd0;
      sr              <= '0;
      cur             <= 8'h00;
      nxt             <= 8'h00;
      io_out          <= 4'h0;
      io_out_en       <= 4'h0;
      mem_addr        <= '0;
      mem_rd_en       <= 1'b0;
      rd_pipe         <= '0;
      continuous_mode <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      rd_pipe   <= (rd_pipe << 1) | MEM_LATENCY'(mem_rd_en);
      if (data_valid) nxt <= mem_data;
      if (csn_s) begin
        cnt       <= 5'd0;
        bcnt      <= 3'd0;
        io_out    <= 4'h0;
        io_out_en <= 4'h0;
      end else begin
        if (rise) begin
          case (state)
            IDLE: begin
              cnt <= 5'd1;
              sr  <= continuous_mode ? {sr[18:0], io_s} : {sr[21:0], io_s[0]};
            end
            CMD, ADDR_S: begin
              cnt <= phase_done ? 5'd0 : cnt + 5'd1;
              sr  <= {sr[21:0], io_s[0]};
            end
            ADDR_Q, MODE: begin
              cnt <= phase_done ? 5'd0 : cnt + 5'd1;
              sr  <= {sr[18:0], io_s};
            end
            DUMMY:   cnt <= phase_done ? 5'd0 : cnt + 5'd1;
            default: ;
          endcase
          if (phase_done && (state == ADDR_S || state == ADDR_Q)) begin
            mem_addr  <= addr_full[ADDR_WIDTH-1:0];
            mem_rd_en <= 1'b1;
            bcnt      <= 3'd0;
          end
          // Mode byte bits [5:4] live in sr[1:0] once the low nibble arrives.
          if (phase_done && state == MODE) continuous_mode <= (sr[1:0] == 2'b10);
        end
        if (fall && (state == DATA_S || state == DATA_Q)) begin
          if (bcnt == 3'd0) begin
            mem_addr  <= mem_addr + ADDR_WIDTH'(1);
            mem_rd_en <= 1'b1;
            if (quad_data) begin
              io_out <= src[7:4];
              cur    <= {src[3:0], 4'h0};
            end else begin
              io_out <= {2'b00, src[7], 1'b0};
              cur    <= {src[6:0], 1'b0};
            end
          end else begin
            if (quad_data) begin
              io_out <= cur[7:4];
              cur    <= {cur[3:0], 4'h0};
            end else begin
              io_out <= {2'b00, cur[7], 1'b0};
              cur    <= {cur[6:0], 1'b0};
            end
          end
          io_out_en <= quad_data ? 4'b1111 : 4'b0010;
          bcnt      <= (bcnt == (quad_data ? 3'd1 : 3'd7)) ? 3'd0 : bcnt + 3'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire
